// File: rtl/aer_event_packer_if.sv
// rtl/aer_event_packer_if.sv - arbiter-side and event-stream signal bundle for aer_event_packer
interface aer_event_packer_if #(
    parameter int Lvl_ROW_ADD = 1,
    parameter int Lvl_COL_ADD = 1,
    parameter int TS_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 8
);
    localparam int EVT_W = 1 + TS_WIDTH + Lvl_ROW_ADD + Lvl_COL_ADD;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                   gnt_valid_i;
    logic [Lvl_ROW_ADD-1:0] xadd_i;
    logic [Lvl_COL_ADD-1:0] yadd_i;
    logic                   polarity_i;
    logic                   grp_release_i;
    logic                   arb_enable_o;
    logic                   arb_refresh_o;
    logic [EVT_W-1:0]       evt_data_o;
    logic                   evt_valid_o;
    logic                   evt_ready_i;
    logic [CNT_W-1:0]       fifo_count_o;
    logic                   overflow_o;

    modport slave (
        input  gnt_valid_i, xadd_i, yadd_i, polarity_i, grp_release_i, evt_ready_i,
        output arb_enable_o, arb_refresh_o, evt_data_o, evt_valid_o, fifo_count_o, overflow_o
    );

    modport master (
        output gnt_valid_i, xadd_i, yadd_i, polarity_i, grp_release_i, evt_ready_i,
        input  arb_enable_o, arb_refresh_o, evt_data_o, evt_valid_o, fifo_count_o, overflow_o
    );
endinterface

// File: rtl/aer_event_packer.sv
// rtl/aer_event_packer.sv - timestamps arbiter grants into AER words, buffers them, paces the arbiter
module aer_event_packer #(
    parameter int Lvl_ROW_ADD = 1,
    parameter int Lvl_COL_ADD = 1,
    parameter int TS_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    aer_event_packer_if.slave  bus
);
    localparam int EVT_W = 1 + TS_WIDTH + Lvl_ROW_ADD + Lvl_COL_ADD;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, REFRESH} state_e;

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] grp_ts_q, grp_ts_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q;
    logic [EVT_W-1:0]    mem_q [FIFO_DEPTH];

    logic full, empty, pop, push_ok, arb_enable, arb_refresh;
    logic [EVT_W-1:0] push_word;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = !empty && bus.evt_ready_i;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok   = bus.gnt_valid_i && (!full || pop);
    assign push_word = {bus.polarity_i, grp_ts_q, bus.xadd_i, bus.yadd_i};
    assign count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    always_comb begin
        state_d     = state_q;
        grp_ts_d    = grp_ts_q;
        arb_enable  = 1'b0;
        arb_refresh = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.grp_release_i) begin
                    grp_ts_d = ts_q;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // Keep one slot free for the grant the arbiter may already have registered.
                arb_enable = (count_q <= CNT_W'(FIFO_DEPTH - 2));
                if (bus.grp_release_i && !bus.gnt_valid_i) begin
                    state_d = REFRESH;
                end
            end
            REFRESH: begin
                arb_refresh = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            grp_ts_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_q + TS_WIDTH'(1);
            grp_ts_q <= grp_ts_d;
            count_q  <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (bus.gnt_valid_i && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.arb_enable_o  = arb_enable;
    assign bus.arb_refresh_o = arb_refresh;
    assign bus.evt_valid_o   = !empty;
    assign bus.evt_data_o    = mem_q[rd_ptr_q];
    assign bus.fifo_count_o  = count_q;
    assign bus.overflow_o    = overflow_q;
endmodule

// File: tb/tb_aer_event_packer.sv
// tb/tb_aer_event_packer.sv - directed plus randomized bench for aer_event_packer against a queue model
module tb_aer_event_packer;
    localparam int RW    = 1;
    localparam int CW    = 1;
    localparam int TSW   = 4;
    localparam int DEPTH = 8;
    localparam int EW    = 1 + TSW + RW + CW;
    localparam int P_IDLE = 0, P_SCAN = 1, P_REFRESH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aer_event_packer_if #(.Lvl_ROW_ADD(RW), .Lvl_COL_ADD(CW), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)) bus ();

    aer_event_packer #(.Lvl_ROW_ADD(RW), .Lvl_COL_ADD(CW), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    int             m_phase, m_ts, m_grp_ts;
    logic           m_ovf;
    logic [EW-1:0]  m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_enable();
        return (m_phase == P_SCAN) && (m_q.size() <= DEPTH - 2);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_ts = 0;
        m_grp_ts = 0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic check_outputs();
        chk("count", 32'(bus.fifo_count_o), 32'(m_q.size()));
        chk("valid", 32'(bus.evt_valid_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("data", 32'(bus.evt_data_o), 32'(m_q[0]));
        chk("enable", 32'(bus.arb_enable_o), 32'(m_enable()));
        chk("refresh", 32'(bus.arb_refresh_o), 32'(m_phase == P_REFRESH));
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    endtask

    task automatic model_step();
        int sz;
        logic pop;
        logic [TSW-1:0] tsv;
        logic [EW-1:0] word;
        sz  = m_q.size();
        pop = (sz > 0) && bus.evt_ready_i;
        tsv = TSW'(m_grp_ts);
        word = {bus.polarity_i, tsv, bus.xadd_i, bus.yadd_i};
        if (pop) void'(m_q.pop_front());
        if (bus.gnt_valid_i) begin
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else m_q.push_back(word);
        end
        case (m_phase)
            P_IDLE:  if (!bus.grp_release_i) begin m_grp_ts = m_ts; m_phase = P_SCAN; end
            P_SCAN:  if (bus.grp_release_i && !bus.gnt_valid_i) m_phase = P_REFRESH;
            default: m_phase = P_IDLE;
        endcase
        m_ts = (m_ts + 1) % (1 << TSW);
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gv, input logic x, input logic y, input logic pol,
                         input logic rel, input logic rdy);
        bus.gnt_valid_i   = gv;
        bus.xadd_i        = x;
        bus.yadd_i        = y;
        bus.polarity_i    = pol;
        bus.grp_release_i = rel;
        bus.evt_ready_i   = rdy;
    endtask

    initial begin
        logic prev_en, cur_en;
        int   npulse;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.fifo_count_o), 0);
        chk("rst_valid", 32'(bus.evt_valid_o), 0);
        chk("rst_enable", 32'(bus.arb_enable_o), 0);
        chk("rst_refresh", 32'(bus.arb_refresh_o), 0);
        chk("rst_overflow", 32'(bus.overflow_o), 0);
        rst = 1'b0;

        // group with requests pending: two grants share one timestamp
        cycle();
        chk("scan_enable", 32'(bus.arb_enable_o), 1);
        drive(1, 0, 1, 1, 0, 0); cycle();
        drive(1, 1, 1, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("word0", 32'(bus.evt_data_o), 32'({1'b1, TSW'(m_grp_ts), 1'b0, 1'b1}));
        cycle();
        drive(0, 0, 0, 0, 0, 1);
        repeat (3) cycle();

        // group end: a single refresh pulse, then quiet idle
        drive(0, 0, 0, 0, 1, 1);
        npulse = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.arb_refresh_o === 1'b1) npulse++;
            cycle();
        end
        chk("refresh_pulses", npulse, 1);
        chk("idle_enable", 32'(bus.arb_enable_o), 0);

        // backpressure: in-flight grant follows each enabled cycle
        prev_en = 1'b0;
        for (int k = 0; k < 15; k++) begin
            drive(prev_en, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
            cur_en = m_enable();
            cycle();
            prev_en = cur_en;
        end
        chk("bp_count", 32'(bus.fifo_count_o), DEPTH);
        chk("bp_ovf", 32'(bus.overflow_o), 0);
        drive(1, 1, 0, 1, 0, 0); cycle();
        chk("ovf_set", 32'(bus.overflow_o), 1);
        chk("ovf_count", 32'(bus.fifo_count_o), DEPTH);

        // full with simultaneous push and pop, then drain in order
        drive(1, 0, 1, 0, 0, 1); cycle();
        chk("full_pp_count", 32'(bus.fifo_count_o), DEPTH);
        drive(0, 0, 0, 0, 0, 1);
        repeat (DEPTH) cycle();
        chk("drained", 32'(bus.fifo_count_o), 0);

        // timestamp wrap: start a group with ts_cnt at its top value
        drive(0, 0, 0, 0, 1, 1);
        repeat (3) cycle();
        for (int k = 0; k < 17 && m_ts != (1 << TSW) - 1; k++) cycle();
        drive(0, 0, 0, 0, 0, 0); cycle();
        drive(1, 1, 1, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0);
        chk("wrap_ts15", 32'(bus.evt_data_o[EW-2 -: TSW]), (1 << TSW) - 1);
        cycle(); cycle();
        drive(0, 0, 0, 0, 0, 1); cycle();
        drive(1, 0, 0, 1, 0, 1); cycle();
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap_next_ts", 32'(bus.evt_data_o[EW-2 -: TSW]), 32'(m_grp_ts));
        cycle();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive((m_enable() && 1'($urandom)) || ($urandom_range(0, 19) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
            cycle();
        end

        // reset mid-SCAN with three words buffered
        drive(0, 0, 0, 0, 0, 1);
        repeat (DEPTH + 3) cycle();
        drive(1, 0, 1, 1, 0, 0); cycle();
        drive(1, 1, 0, 0, 0, 0); cycle();
        drive(1, 1, 1, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_rst_count", 32'(bus.fifo_count_o), 3);
        check_outputs();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.fifo_count_o), 0);
        chk("arst_valid", 32'(bus.evt_valid_o), 0);
        chk("arst_enable", 32'(bus.arb_enable_o), 0);
        chk("arst_refresh", 32'(bus.arb_refresh_o), 0);
        chk("arst_overflow", 32'(bus.overflow_o), 0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_refresh", 32'(bus.arb_refresh_o), 0);
            chk("rst_hold_count", 32'(bus.fifo_count_o), 0);
        end
        drive(0, 0, 0, 0, 1, 1);
        rst = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aer_event_packer.md
# aer_event_packer

Downstream stage of the row round-robin arbiter in the pixel-level hierarchy. Each registered grant plus row/column address and polarity becomes one timestamped address-event word, buffered in a small FIFO and drained over a valid/ready port. The block drives the arbiter's `enable_i`/`refresh_i` so that the arbiter only advances when buffer space exists, and it re-arms the arbiter after each group completes.

## Interface
Parameters:
- `Lvl_ROW_ADD`, 1: row address width; matches arbiter `xadd_o`.
- `Lvl_COL_ADD`, 1: column address width.
- `TS_WIDTH`, 16: timestamp counter width.
- `FIFO_DEPTH`, 8: event buffer entries; power of 2, ≥4.
- Derived `EVT_W` = 1+TS_WIDTH+Lvl_ROW_ADD+Lvl_COL_ADD.

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `gnt_valid_i`  in  1  arbiter grant registered this cycle (|gnt_o); qualifies address inputs.
- `xadd_i`  in  Lvl_ROW_ADD  granted row address.
- `yadd_i`  in  Lvl_COL_ADD  column address of the event.
- `polarity_i`  in  1  event polarity (1 = ON).
- `grp_release_i`  in  1  arbiter reports no masked requests remain.
- `arb_enable_o`  out  1  drives arbiter `enable_i`.
- `arb_refresh_o`  out  1  drives arbiter `refresh_i`; one-cycle pulse.
- `evt_data_o`  out  EVT_W  {polarity, timestamp, xadd, yadd}, MSB first.
- `evt_valid_o`  out  1  FIFO non-empty.
- `evt_ready_i`  in  1  consumer accepts the head word.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `overflow_o`  out  1  sticky; a grant arrived while the FIFO was full with no pop.

## Operation
- Free-running `ts_cnt` (TS_WIDTH) increments every cycle and wraps modulo 2^TS_WIDTH.
- FSM states: IDLE, SCAN, REFRESH.
  - IDLE: `arb_enable_o`=0. If `grp_release_i`=0, latch `grp_ts` ← `ts_cnt` and go to SCAN.
  - SCAN: `arb_enable_o` = (count ≤ FIFO_DEPTH−2). This leaves one slot for the grant already in flight. If `grp_release_i`=1 and `gnt_valid_i`=0, go to REFRESH.
  - REFRESH: `arb_refresh_o`=1 for exactly this cycle, `arb_enable_o`=0. Then go to IDLE.
- All events of one group carry the same `grp_ts`.
- Push: occurs on any cycle with `gnt_valid_i`=1, in any state. The pushed word is {polarity_i, grp_ts, xadd_i, yadd_i}.
- Pop: occurs when `evt_valid_o` && `evt_ready_i`.
- Full and push without pop: the word is dropped, `overflow_o` ← 1, and count is unchanged.
- Full and push with pop in the same cycle: both are accepted, and count stays at FIFO_DEPTH.
- Empty and push in the same cycle: no pop is possible (`evt_valid_o`=0). The word appears next cycle.
- The FIFO is first-word fall-through: `evt_data_o` = mem[rd_ptr]. Pointers wrap modulo FIFO_DEPTH.
- `overflow_o` is cleared only by reset.

## Timing
- Reset values: state=IDLE, `ts_cnt`=0, `grp_ts`=0, pointers=0, `arb_enable_o`=0, `arb_refresh_o`=0, `evt_valid_o`=0, `fifo_count_o`=0, `overflow_o`=0, `evt_data_o`=mem[0] (don't-care while not valid).
- Reset asserted mid-group returns the block to IDLE immediately and discards FIFO contents. No refresh pulse is issued.
- `arb_enable_o`, `arb_refresh_o`, and `evt_valid_o` are decoded combinationally from registered state and count only. There is no combinational path from inputs to outputs except `evt_data_o` mux select by `rd_ptr`.
- Latency: `gnt_valid_i` at cycle N gives `evt_valid_o`=1 with that word at N+1 when the FIFO was empty.
- Group entry: `grp_release_i` falls at N gives SCAN and `arb_enable_o`=1 at N+1.
- Group exit: last condition seen at N gives REFRESH at N+1 (pulse) and IDLE at N+2.
- Throughput: 1 event/cycle while the consumer holds `evt_ready_i`=1.

## Test plan
- Reset release, requests pending (`grp_release_i`=0): SCAN at the 2nd edge, `arb_enable_o`=1. Two grants with x=0,1, y=1, pol=1 produce words {1,grp_ts,0,1} then {1,grp_ts,1,1}, both with the identical timestamp latched at SCAN entry.
- Group end: `grp_release_i`=1 with no grant gives exactly one `arb_refresh_o` pulse, then IDLE. With `grp_release_i` held at 1, there is no further enable or refresh.
- Backpressure: `evt_ready_i`=0, FIFO_DEPTH=8. `arb_enable_o` drops when count=7. The in-flight grant fills the FIFO to 8 and `overflow_o` stays 0. A forced extra grant sets `overflow_o`=1 with count still 8.
- Full with simultaneous push and pop: count stays 8, order is preserved, and the next 8 pops return the words in push order, including the new one.
- Timestamp wrap (TS_WIDTH=4): a group started at `ts_cnt`=15 carries ts=15, and the next group carries the wrapped value (0 to 15 as latched).
- Reset asserted mid-SCAN with 3 words buffered: all outputs return to reset values asynchronously, with no `arb_refresh_o` pulse.
